// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-control types and constants for the MIPS pipeline
package mips_pkg;
  typedef enum logic [1:0] {BOOT, RUN, PEND} pc_state_t;
  typedef enum logic [1:0] {SRC_SEQ, SRC_BR, SRC_JMP} redir_src_t;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/ex_pc_calc.sv
// ex_pc_calc: EX-stage branch target, pc_plus4 + (offset << 2) mod 2^32
module ex_pc_calc (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] offset,
  output logic [31:0] target
);
  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[31:30];
  assign target = pc_plus4 + {offset[29:0], 2'b00};
endmodule

// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller: fetch PC owner arbitrating sequential, branch and jump redirects
// DELAY_SLOT_EN selects MIPS delay-slot flush behaviour
module pc_redirect_controller
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  input  logic              fetch_ready,
  output logic              if_kill,
  input  logic              stall,
  input  logic              ex_branch_valid,
  input  logic              ex_branch_taken,
  input  logic [31:0]       ex_pc_plus4,
  input  logic [31:0]       ex_offset,
  input  logic              id_jump_valid,
  input  logic [31:0]       id_pc_plus4,
  input  logic [25:0]       id_jump_index,
  output logic              flush_if_id,
  output logic              flush_id_ex
);
`ifdef DELAY_SLOT_EN
  localparam logic BR_FLUSH_ID_EX = 1'b0;
  localparam logic JMP_FLUSH_IF_ID = 1'b0;
`else
  localparam logic BR_FLUSH_ID_EX = 1'b1;
  localparam logic JMP_FLUSH_IF_ID = 1'b1;
`endif
  pc_state_t         state, next_state;
  redir_src_t        src;
  logic [ADDR_W-1:0] pend_tgt, pc_nxt, pend_nxt, tgt, br_tgt, j_tgt;
  logic              br, jmp;
  logic              unused_id_pc;
  assign unused_id_pc = ^id_pc_plus4[27:0];
  ex_pc_calc u_calc (.pc_plus4(ex_pc_plus4), .offset(ex_offset), .target(br_tgt));
  assign j_tgt = {id_pc_plus4[31:28], id_jump_index, 2'b00};
  assign br    = ex_branch_valid & ex_branch_taken;
  assign jmp   = id_jump_valid & !stall;
  assign src   = br ? SRC_BR : jmp ? SRC_JMP : SRC_SEQ;
  assign tgt   = (src == SRC_BR) ? br_tgt : j_tgt;
  always_comb begin
    next_state  = state;
    pc_nxt      = pc;
    pend_nxt    = pend_tgt;
    if_kill     = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        flush_if_id = (src == SRC_BR) | ((src == SRC_JMP) & JMP_FLUSH_IF_ID);
        flush_id_ex = (src == SRC_BR) & BR_FLUSH_ID_EX;
        if (src != SRC_SEQ) begin
          if (fetch_ready) pc_nxt = tgt;
          else begin
            pend_nxt   = tgt;
            next_state = PEND;
          end
        end else if (fetch_ready && !stall) pc_nxt = pc + PC_STEP;
      end
      PEND: begin
        // jumps here belong to the already-flushed younger path
        flush_if_id = br;
        flush_id_ex = br & BR_FLUSH_ID_EX;
        pend_nxt    = br ? br_tgt : pend_tgt;
        if (fetch_ready) begin
          if_kill    = 1'b1;
          pc_nxt     = pend_nxt;
          next_state = RUN;
        end
      end
      default: next_state = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      pend_tgt <= RESET_VECTOR;
      pc_valid <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_nxt;
      pend_tgt <= pend_nxt;
      pc_valid <= next_state != BOOT;
    end
  end
endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller: directed self-checking bench for pc_redirect_controller
module tb_pc_redirect_controller;
`ifdef DELAY_SLOT_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif
  logic        clk = 0, rst_n = 1;
  logic [31:0] pc;
  logic        pc_valid, fetch_ready, if_kill, stall;
  logic        ex_branch_valid, ex_branch_taken, id_jump_valid;
  logic [31:0] ex_pc_plus4, ex_offset, id_pc_plus4;
  logic [25:0] id_jump_index;
  logic        flush_if_id, flush_id_ex;
  int          checks = 0, errors = 0;
  pc_redirect_controller dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .fetch_ready(fetch_ready),
    .if_kill(if_kill), .stall(stall), .ex_branch_valid(ex_branch_valid),
    .ex_branch_taken(ex_branch_taken), .ex_pc_plus4(ex_pc_plus4), .ex_offset(ex_offset),
    .id_jump_valid(id_jump_valid), .id_pc_plus4(id_pc_plus4), .id_jump_index(id_jump_index),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic branch(input logic [31:0] p4, input logic [31:0] off);
    ex_branch_valid = 1; ex_branch_taken = 1; ex_pc_plus4 = p4; ex_offset = off;
  endtask
  task automatic idle();
    ex_branch_valid = 0; ex_branch_taken = 0; id_jump_valid = 0;
  endtask
  initial begin
    fetch_ready = 1; stall = 0; idle();
    ex_pc_plus4 = 0; ex_offset = 0; id_pc_plus4 = 0; id_jump_index = 0;
    #2 rst_n = 0;
    #11;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_kill", {31'b0, if_kill}, 32'd0);
    rst_n = 1;
    branch(32'h4, 32'h2);
    #1;
    check("boot_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
    idle();
    tick();
    check("t1_pc0", pc, 32'h0);
    check("t1_valid", {31'b0, pc_valid}, 32'd1);
    tick(); check("t1_pc4", pc, 32'h4);
    tick(); check("t1_pc8", pc, 32'h8);
    branch(32'h4, 32'h2);
    #1;
    check("t2_fl_ifid", {31'b0, flush_if_id}, 32'd1);
    check("t2_fl_idex", {31'b0, flush_id_ex}, {31'b0, ~DS});
    tick(); check("t2_pc", pc, 32'hC);
    branch(32'h100, 32'hFFFF_FFFE);
    tick(); check("t3_pc", pc, 32'hF8);
    stall = 1;
    tick(); check("t3_stall_pc", pc, 32'hF8);
    idle();
    tick(); check("t3_seq_stall", pc, 32'hF8);
    stall = 0;
    id_jump_valid = 1; id_pc_plus4 = 32'h4000_0010; id_jump_index = 26'h10;
    #1;
    check("t4_fl_ifid", {31'b0, flush_if_id}, {31'b0, ~DS});
    check("t4_fl_idex", {31'b0, flush_id_ex}, 32'd0);
    tick(); check("t4_pc", pc, 32'h4000_0040);
    stall = 1;
    #1;
    check("t4_stall_fl", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
    tick(); check("t4_stall_pc", pc, 32'h4000_0040);
    idle(); stall = 0;
    fetch_ready = 0;
    branch(32'h1F8, 32'h2);
    tick(); check("t5_hold0", pc, 32'h4000_0040);
    idle();
    tick(); check("t5_hold1", pc, 32'h4000_0040);
    check("t5_valid", {31'b0, pc_valid}, 32'd1);
    tick(); check("t5_hold2", pc, 32'h4000_0040);
    check("t5_nokill", {31'b0, if_kill}, 32'd0);
    fetch_ready = 1;
    #1;
    check("t5_kill", {31'b0, if_kill}, 32'd1);
    check("t5_nofl", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
    tick(); check("t5_pc", pc, 32'h200);
    check("t5_kill_off", {31'b0, if_kill}, 32'd0);
    branch(32'h2F8, 32'h2);
    id_jump_valid = 1; id_pc_plus4 = 32'h1000_0000; id_jump_index = 26'h123;
    tick(); check("t6_br_wins", pc, 32'h300);
    idle();
    branch(32'h0, 32'hFFFF_FFFF);
    tick(); check("t6_pc_top", pc, 32'hFFFF_FFFC);
    idle();
    tick(); check("t6_wrap", pc, 32'h0);
    fetch_ready = 0;
    branch(32'h500, 32'h0);
    tick(); idle();
    check("t6_pend_hold", pc, 32'h0);
    tick(); tick(); tick();
    check("t6_pend_hold2", pc, 32'h0);
    fetch_ready = 1;
    #1 rst_n = 0;
    #1;
    check("t6_rst_pc", pc, 32'h0);
    check("t6_rst_valid", {31'b0, pc_valid}, 32'd0);
    check("t6_rst_kill", {31'b0, if_kill}, 32'd0);
    #10 rst_n = 1;
    tick(); tick();
    check("t6_after_rst", pc, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
